// File: rtl/lab5_mcore_mem_arbiter.sv
// lab5_mcore_mem_arbiter
//   Shares one 16B memory port among four cache refill requesters.
//   Round-robin grant into a one-entry registered request buffer; each
//   accepted request is tagged with its requester id in opaque[7:6], and
//   memory responses are steered back by that tag (tag cleared on return).
//   A 3-bit counter per requester bounds its in-flight requests.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   req_val/req_rdy/req_msg per-requester request handshake + mem_req_16B_t
//   resp_val/resp_rdy/resp_msg per-requester response handshake + mem_resp_16B_t
//   memreq_*                request port to memory
//   memresp_*               response port from memory
//   err                     sticky flag: response for a requester with nothing in flight
//
// Message layouts
//   mem_req_16B_t  (175b): type[174:172] opaque[171:164] addr[163:132] len[131:128] data[127:0]
//   mem_resp_16B_t (145b): type[144:142] opaque[141:134] test[133:132] len[131:128] data[127:0]

module lab5_mcore_mem_arbiter #(
   parameter int unsigned p_num_reqs        = 4,
   parameter int unsigned p_max_outstanding = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [p_num_reqs-1:0]        req_val,
   output logic [p_num_reqs-1:0]        req_rdy,
   input  logic [p_num_reqs-1:0][174:0] req_msg,
   output logic [p_num_reqs-1:0]        resp_val,
   input  logic [p_num_reqs-1:0]        resp_rdy,
   output logic [p_num_reqs-1:0][144:0] resp_msg,
   output logic                         memreq_val,
   input  logic                         memreq_rdy,
   output logic [174:0]                 memreq_msg,
   input  logic                         memresp_val,
   output logic                         memresp_rdy,
   input  logic [144:0]                 memresp_msg,
   output logic                         err
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_e;

   buf_state_e            state_q, state_d;
   logic [174:0]          buf_q, buf_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [3:0][2:0]       cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic [3:0]            elig;
   logic [1:0]            gnt;
   logic                  gnt_vld;
   logic                  can_accept;
   logic                  accept;
   logic [174:0]          req_rw;
   logic [1:0]            dst;
   logic                  resp_fire;

   // Eligibility: valid and still below the in-flight limit.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         elig[i] = req_val[i] && (cnt_q[i] < 3'(p_max_outstanding));
      end
   end

   // Round-robin scan starting at ptr_q; first eligible index wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (!gnt_vld && elig[ptr_q + 2'(k)]) begin
            gnt     = ptr_q + 2'(k);
            gnt_vld = 1'b1;
         end
      end
   end

   // A full buffer can take a new request only in the cycle it drains.
   assign can_accept = (state_q == ST_EMPTY) || memreq_rdy;
   assign accept     = gnt_vld && can_accept && !reset;

   always_comb begin
      req_rdy = '0;
      if (accept) begin
         req_rdy[gnt] = 1'b1;
      end
   end

   // Tag the granted request with its requester id.
   always_comb begin
      req_rw            = req_msg[gnt];
      req_rw[171:170]   = gnt;
   end

   // Buffer FSM and round-robin pointer.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      ptr_d   = ptr_q;
      if (accept) begin
         state_d = ST_FULL;
         buf_d   = req_rw;
         ptr_d   = gnt + 2'd1;
      end else if ((state_q == ST_FULL) && memreq_rdy) begin
         state_d = ST_EMPTY;
      end
   end

   assign memreq_val = (state_q == ST_FULL);
   assign memreq_msg = buf_q;

   // Response steering by the returned tag; fully combinational.
   assign dst         = memresp_msg[141:140];
   assign memresp_rdy = resp_rdy[dst];
   assign resp_fire   = memresp_val && memresp_rdy;

   always_comb begin
      resp_val = '0;
      resp_msg = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         resp_val[i]            = memresp_val && (dst == 2'(i));
         resp_msg[i]            = memresp_msg;
         resp_msg[i][141:140]   = 2'b00;
      end
   end

   // Outstanding counters; a return with nothing in flight flags err.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (accept && (gnt == 2'(i))) begin
            if (!(resp_fire && (dst == 2'(i)))) begin
               cnt_d[i] = cnt_q[i] + 3'd1;
            end
         end else if (resp_fire && (dst == 2'(i))) begin
            if (cnt_q[i] == 3'd0) begin
               err_d = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - 3'd1;
            end
         end
      end
   end

   assign err = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         buf_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule
